ysyx_24100005_lsu: RTL and testbench

//  Multi-cycle load/store unit between EXU and data memory; replaces inline DPI read in top.

---
 rtl/ysyx_24100005_lsu.sv | 198 +++++++++++++++++++
 tb/tb_ysyx_24100005_lsu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: one EXU access at a time, aligned word requests with byte strobes.
// LSU_MISALIGN_TRAP_EN: defined -> misaligned access responds with resp_err; undefined -> address is aligned down.
module ysyx_24100005_lsu #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [1:0]            dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the valid side holds its payload stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t              state, state_d;
  logic [31:0]         cnt, cnt_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                err_d;
  logic                r_wen;
  logic [2:0]          r_funct3;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic [ADDR_W-1:0]   lo_mask;
  logic [ADDR_W-1:0]   eff_addr;
  logic                illegal_in;
  logic                misalign_trap;
  logic                timeout_hit;
  logic [OFF_W-1:0]    off;
  logic [STRB_W-1:0]   size_strb;
  logic [DATA_W-1:0]   sh;
  logic [DATA_W-1:0]   keep;
  logic                sgn;
  logic [DATA_W-1:0]   ld_data;

  always_comb begin
    case (req_funct3[1:0])
      2'd0:    lo_mask = '0;
      2'd1:    lo_mask = ADDR_W'(1);
      2'd2:    lo_mask = ADDR_W'(3);
      default: lo_mask = ADDR_W'(7);
    endcase
  end

  assign illegal_in = (req_funct3[2:1] == 2'b11) ||
                      ((req_funct3 == 3'b011) && (DATA_W == 32)) ||
                      (req_funct3[2] && req_wen);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_trap = |(req_addr & lo_mask);
  assign eff_addr      = req_addr;
`else
  assign misalign_trap = 1'b0;
  assign eff_addr      = req_addr & ~lo_mask;
`endif

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);

  // Memory side is driven straight from the captured request, so it is stable through REQ.
  assign off       = r_addr[OFF_W-1:0];
  assign mem_valid = (state == REQ);
  assign mem_wen   = r_wen;
  assign mem_addr  = r_addr & ~ADDR_W'(STRB_W - 1);
  assign mem_wdata = r_wdata << {off, 3'b000};

  always_comb begin
    case (r_funct3[1:0])
      2'd0:    size_strb = STRB_W'(1);
      2'd1:    size_strb = STRB_W'(3);
      2'd2:    size_strb = STRB_W'(15);
      default: size_strb = '1;
    endcase
  end

  assign mem_wstrb = r_wen ? (size_strb << off) : '0;

  // Load extraction: keep the low access-size bits, fill the rest with sign or zero.
  assign sh = mem_rdata >> {off, 3'b000};

  always_comb begin
    int nbits;
    nbits = 8 << r_funct3[1:0];
    if (nbits > DATA_W) nbits = DATA_W;
    sgn  = 1'b0;
    keep = '0;
    for (int i = 0; i < DATA_W; i++) begin
      keep[i] = (i < nbits);
      if (i == nbits - 1) sgn = sh[i];
    end
    sgn     = sgn & ~r_funct3[2];
    ld_data = (sh & keep) | ({DATA_W{sgn}} & ~keep);
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign dbg_state  = state;

  always_comb begin
    state_d = state;
    rdata_d = resp_rdata;
    err_d   = resp_err;
    cnt_d   = cnt + 32'd1;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          if (illegal_in || misalign_trap) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (r_wen) begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = ld_data;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      r_wen      <= 1'b0;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      resp_rdata <= rdata_d;
      resp_err   <= err_d;
      if (state == IDLE && req_valid) begin
        r_wen    <= req_wen;
        r_funct3 <= req_funct3;
        r_addr   <= eff_addr;
        r_wdata  <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Directed plus small random bench for ysyx_24100005_lsu with a response scoreboard.
module tb_ysyx_24100005_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  logic        err_q[$];
  int          checks = 0;
  int          errors = 0;

  ysyx_24100005_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: one access with an immediately ready memory; exp_lat = cycles from accept to resp_valid.
  task automatic access(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic [31:0] exp_maddr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wd, input int exp_lat);
    int n;
    int hold;
    logic [31:0] e_rd;
    logic e_err;
    logic mem_exp;
    exp_q.push_back(exp_rd);
    err_q.push_back(exp_err);
    mem_exp = (exp_lat > 1);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_ready = 1'b1;
    step();
    req_valid = 1'b0;
    n = 1;
    chk("mem_valid_req", {31'd0, mem_valid}, {31'd0, mem_exp});
    if (mem_exp) begin
      chk("mem_addr", mem_addr, exp_maddr);
      chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_strb});
      chk("mem_wen", {31'd0, mem_wen}, {31'd0, wen});
      if (wen) chk("mem_wdata", mem_wdata, exp_wd);
      step();
      n = 2;
      mem_ready = 1'b0;
      if (!wen) begin
        chk("mem_valid_wait", {31'd0, mem_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        n = 3;
        mem_rvalid = 1'b0;
      end
    end
    mem_ready = 1'b0;
    while (!resp_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    // Scoreboard pop on the DUT response, then hold it for a few cycles with resp_ready low.
    e_rd  = exp_q.pop_front();
    e_err = err_q.pop_front();
    hold  = $urandom_range(0, 2);
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("resp_rdata", resp_rdata, e_rd);
      chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
      if (h < hold) step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int n;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] word, sh, exp_v, addr;
    logic [2:0]  f3_tab[5];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    // LB / LHU / SB examples
    access(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FFFFFF, 32'hFFFFFF80, 1'b0, 32'h1000, 4'b0000, 32'h0, 3);
    access(1'b0, 3'b101, 32'h1002, 32'h0, 32'hBEEF1234, 32'h0000BEEF, 1'b0, 32'h1000, 4'b0000, 32'h0, 3);
    access(1'b1, 3'b000, 32'h2001, 32'h000000AB, 32'h0, 32'h0, 1'b0, 32'h2000, 4'b0010, 32'h0000AB00, 2);
`ifdef LSU_MISALIGN_TRAP_EN
    access(1'b0, 3'b010, 32'h3002, 32'h0, 32'hCAFEF00D, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 1);
    access(1'b1, 3'b001, 32'h3003, 32'h5555, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 1);
`else
    access(1'b0, 3'b010, 32'h3002, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 32'h3000, 4'b0000, 32'h0, 3);
    access(1'b1, 3'b001, 32'h3003, 32'h5555, 32'h0, 32'h0, 1'b0, 32'h3000, 4'b1100, 32'h55550000, 2);
`endif
    access(1'b0, 3'b001, 32'h1002, 32'h0, 32'h80011234, 32'hFFFF8001, 1'b0, 32'h1000, 4'b0000, 32'h0, 3);
    access(1'b0, 3'b100, 32'h1001, 32'h0, 32'h0000C300, 32'h000000C3, 1'b0, 32'h1000, 4'b0000, 32'h0, 3);
    access(1'b1, 3'b001, 32'h4002, 32'h00001234, 32'h0, 32'h0, 1'b0, 32'h4000, 4'b1100, 32'h12340000, 2);
    access(1'b1, 3'b010, 32'h5000, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 32'h5000, 4'b1111, 32'hDEADBEEF, 2);
    access(1'b0, 3'b010, 32'h6000, 32'h0, 32'h12345678, 32'h12345678, 1'b0, 32'h6000, 4'b0000, 32'h0, 3);
    // Illegal accesses: LD on a 32-bit bus, funct3 11x, unsigned store
    access(1'b0, 3'b011, 32'h7000, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 1);
    access(1'b0, 3'b110, 32'h7000, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 1);
    access(1'b1, 3'b100, 32'h7001, 32'hFF, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 1);

    // Random aligned loads against a byte-slicing reference
    for (int k = 0; k < 8; k++) begin
      f3   = f3_tab[$urandom_range(0, 4)];
      off  = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'd1) off[0] = 1'b0;
      if (f3[1:0] == 2'd2) off = 2'd0;
      addr = {18'h0, 12'($urandom_range(0, 4095)), off};
      word = $urandom;
      sh   = word >> (8 * off);
      case (f3)
        3'b000:  exp_v = {{24{sh[7]}}, sh[7:0]};
        3'b100:  exp_v = {24'd0, sh[7:0]};
        3'b001:  exp_v = {{16{sh[15]}}, sh[15:0]};
        3'b101:  exp_v = {16'd0, sh[15:0]};
        default: exp_v = word;
      endcase
      access(1'b0, f3, addr, 32'h0, word, exp_v, 1'b0, {addr[31:2], 2'b00}, 4'b0000, 32'h0, 3);
    end

    // Timeout in REQ: memory never ready
    exp_q.push_back(32'h0);
    err_q.push_back(1'b1);
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000;
    mem_ready = 1'b0;
    step();
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin
      step();
      n++;
    end
    chk("timeout_req_window", {31'd0, (n >= 5 && n <= 6)}, 32'd1);
    chk("timeout_req_valid", {31'd0, resp_valid}, 32'd1);
    chk("timeout_req_rdata", resp_rdata, exp_q.pop_front());
    chk("timeout_req_err", {31'd0, resp_err}, {31'd0, err_q.pop_front()});
    chk("timeout_req_memv", {31'd0, mem_valid}, 32'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("timeout_req_memv_after", {31'd0, mem_valid}, 32'd0);

    // Timeout in WAIT, then a late rvalid must not create a response
    exp_q.push_back(32'h0);
    err_q.push_back(1'b1);
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h9000; mem_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    mem_ready = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      step();
      n++;
    end
    chk("timeout_wait_valid", {31'd0, resp_valid}, 32'd1);
    chk("timeout_wait_rdata", resp_rdata, exp_q.pop_front());
    chk("timeout_wait_err", {31'd0, resp_err}, {31'd0, err_q.pop_front()});
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_rvalid = 1'b0;
    chk("late_rvalid_ignored", {31'd0, resp_valid}, 32'd0);
    chk("late_rvalid_idle", {31'd0, req_ready}, 32'd1);

    // Reset pulsed in WAIT drops the transaction
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'hA000; mem_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    mem_ready = 1'b0;
    chk("pre_rst_state_wait", {30'd0, dbg_state}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    chk("rst_mid_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_mem_valid", {31'd0, mem_valid}, 32'd0);
    step();
    chk("rst_mid_still_idle", {31'd0, req_ready}, 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
